// File: rtl/tape_pkg.sv
// Shared state encoding, button/command bit positions and state-to-command decode for the tape transport.
// Zero latency (constants and pure functions only); no flow control involved.
package tape_pkg;

    localparam int STATE_W = 4;
    localparam int BTN_W   = 6;
    localparam int CMD_W   = 6;

    // Button and command vectors share one bit order: stop, pause, fwd, rew, play, rec.
    localparam int BTN_STOP  = 5;
    localparam int BTN_PAUSE = 4;
    localparam int BTN_FWD   = 3;
    localparam int BTN_REW   = 2;
    localparam int BTN_PLAY  = 1;
    localparam int BTN_REC   = 0;

    typedef enum logic [STATE_W-1:0] {
        ST_STOP      = 4'd0,
        ST_WILL_FWD  = 4'd1,
        ST_FWD       = 4'd2,
        ST_WILL_REW  = 4'd3,
        ST_REW       = 4'd4,
        ST_WILL_PLAY = 4'd5,
        ST_PLAY      = 4'd6,
        ST_WILL_REC  = 4'd7,
        ST_REC       = 4'd8,
        ST_PAUSE     = 4'd9,
        ST_FAULT     = 4'd10
    } state_t;

    function automatic logic [CMD_W-1:0] cmd_decode(input state_t s);
        logic [CMD_W-1:0] c;
        c = '0;
        case (s)
            ST_PAUSE: c[BTN_PAUSE] = 1'b1;
            ST_FWD:   c[BTN_FWD]   = 1'b1;
            ST_REW:   c[BTN_REW]   = 1'b1;
            ST_PLAY:  c[BTN_PLAY]  = 1'b1;
            ST_REC:   c[BTN_REC]   = 1'b1;
            default:  c[BTN_STOP]  = 1'b1;
        endcase
        return c;
    endfunction

    function automatic logic is_will(input state_t s);
        return (s == ST_WILL_FWD) || (s == ST_WILL_REW) ||
               (s == ST_WILL_PLAY) || (s == ST_WILL_REC);
    endfunction

endpackage

// File: rtl/tape_transport_ctrl_if.sv
// Button, mechanism-status and motor-command bundle between the deck front panel and the transport controller.
// Pure wiring, zero latency; level signals only, so there is no backpressure.
interface tape_transport_ctrl_if #(
    parameter int POS_W = 16
);
    import tape_pkg::*;

    logic                stop_button;
    logic                pause_button;
    logic                forward_button;
    logic                rewind_button;
    logic                play_button;
    logic                record_button;
    logic                is_stopped;
    logic                stop_tape;
    logic                pause_tape;
    logic                forward_tape;
    logic                rewind_tape;
    logic                play_tape;
    logic                record_tape;
    logic                fault;
    logic [STATE_W-1:0]  state;
    logic [POS_W-1:0]    tape_pos;

    modport master (
        output stop_button, pause_button, forward_button, rewind_button,
               play_button, record_button, is_stopped,
        input  stop_tape, pause_tape, forward_tape, rewind_tape, play_tape,
               record_tape, fault, state, tape_pos
    );

    modport slave (
        input  stop_button, pause_button, forward_button, rewind_button,
               play_button, record_button, is_stopped,
        output stop_tape, pause_tape, forward_tape, rewind_tape, play_tape,
               record_tape, fault, state, tape_pos
    );

endinterface

// File: rtl/tape_transport_ctrl_button_edge.sv
// Rising-edge detector for a vector of level buttons: one-cycle pulse on each 0->1 transition.
// Pulse is combinational against a registered previous level; no backpressure.
module button_edge #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= '0;
        end else begin
            prev <= level;
        end
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/tape_transport_ctrl.sv
// Tape transport FSM: button edges -> settle-guarded mode changes, Moore motor commands, saturating tape position.
// One-cycle response to button edges; define TAPE_PAUSE_TIMEOUT_EN to auto-stop after PAUSE_TIMEOUT idle PAUSE cycles.
module tape_transport_ctrl #(
    parameter int POS_W         = 16,
    parameter int FAST_STEP     = 4,
    parameter int SETTLE_MAX    = 255,
    parameter int PAUSE_TIMEOUT = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    tape_transport_ctrl_if.slave bus
);
    import tape_pkg::*;

    localparam int SET_W = (SETTLE_MAX > 1) ? $clog2(SETTLE_MAX) : 1;
    localparam logic [CMD_W-1:0] CMD_RESET = cmd_decode(ST_STOP);

    logic [BTN_W-1:0] btn_level;
    logic [BTN_W-1:0] rise;
    state_t           state_q;
    state_t           nxt;
    logic [CMD_W-1:0] cmd_q;
    logic             fault_q;
    logic [SET_W-1:0] settle_cnt;
    logic             settle_last;
    logic             enter_will;
    logic             at_limit;
    logic             pause_last;
    logic [POS_W-1:0] pos_q;
    logic [POS_W:0]   pos_up_one;
    logic [POS_W:0]   pos_up_fast;

`ifdef TAPE_PAUSE_TIMEOUT_EN
    localparam int PAU_W = (PAUSE_TIMEOUT > 1) ? $clog2(PAUSE_TIMEOUT) : 1;
    logic [PAU_W-1:0] pause_cnt;
    assign pause_last = (pause_cnt == PAU_W'(PAUSE_TIMEOUT - 1));
`else
    assign pause_last = 1'b0;
`endif

    assign btn_level = {bus.stop_button, bus.pause_button, bus.forward_button,
                        bus.rewind_button, bus.play_button, bus.record_button};

    button_edge #(.WIDTH(BTN_W)) u_btn_edge (
        .clk   (clk),
        .reset (reset),
        .level (btn_level),
        .rise  (rise)
    );

    assign settle_last = (settle_cnt == SET_W'(SETTLE_MAX - 1));

    // End of tape forces a stop; only an explicit stop edge outranks it.
    assign at_limit = (((state_q == ST_FWD) || (state_q == ST_PLAY) || (state_q == ST_REC)) &&
                       (pos_q == '1)) ||
                      ((state_q == ST_REW) && (pos_q == '0));

    always_comb begin
        nxt        = state_q;
        enter_will = 1'b0;
        if (state_q == ST_FAULT) begin
            if (rise[BTN_STOP]) nxt = ST_STOP;
        end else if (rise[BTN_STOP] || at_limit) begin
            nxt = ST_STOP;
        end else if (rise[BTN_PLAY] && rise[BTN_REC]) begin
            nxt        = ST_WILL_REC;
            enter_will = 1'b1;
        end else if (rise[BTN_PLAY]) begin
            nxt        = ST_WILL_PLAY;
            enter_will = 1'b1;
        end else if (rise[BTN_FWD]) begin
            nxt        = ST_WILL_FWD;
            enter_will = 1'b1;
        end else if (rise[BTN_REW]) begin
            nxt        = ST_WILL_REW;
            enter_will = 1'b1;
        end else begin
            case (state_q)
                ST_WILL_FWD:  if (bus.is_stopped) nxt = ST_FWD;  else if (settle_last) nxt = ST_FAULT;
                ST_WILL_REW:  if (bus.is_stopped) nxt = ST_REW;  else if (settle_last) nxt = ST_FAULT;
                ST_WILL_PLAY: if (bus.is_stopped) nxt = ST_PLAY; else if (settle_last) nxt = ST_FAULT;
                ST_WILL_REC:  if (bus.is_stopped) nxt = ST_REC;  else if (settle_last) nxt = ST_FAULT;
                ST_PLAY:      if (rise[BTN_PAUSE]) nxt = ST_PAUSE;
                ST_PAUSE:     if (rise[BTN_PAUSE]) nxt = ST_PLAY; else if (pause_last) nxt = ST_STOP;
                default:      nxt = state_q;
            endcase
        end
    end

    // Commands and fault are registered from the next state so they always mirror state_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_STOP;
            cmd_q      <= CMD_RESET;
            fault_q    <= 1'b0;
            settle_cnt <= '0;
`ifdef TAPE_PAUSE_TIMEOUT_EN
            pause_cnt  <= '0;
`endif
        end else begin
            state_q <= nxt;
            cmd_q   <= cmd_decode(nxt);
            fault_q <= (nxt == ST_FAULT);
            if (enter_will) begin
                settle_cnt <= '0;
            end else if (is_will(state_q)) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
`ifdef TAPE_PAUSE_TIMEOUT_EN
            if ((nxt == ST_PAUSE) && (state_q != ST_PAUSE)) begin
                pause_cnt <= '0;
            end else if (state_q == ST_PAUSE) begin
                pause_cnt <= pause_cnt + 1'b1;
            end
`endif
        end
    end

    assign pos_up_one  = {1'b0, pos_q} + (POS_W+1)'(1);
    assign pos_up_fast = {1'b0, pos_q} + (POS_W+1)'(FAST_STEP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_q <= '0;
        end else begin
            case (state_q)
                ST_PLAY, ST_REC: pos_q <= pos_up_one[POS_W]  ? '1 : pos_up_one[POS_W-1:0];
                ST_FWD:          pos_q <= pos_up_fast[POS_W] ? '1 : pos_up_fast[POS_W-1:0];
                ST_REW:          pos_q <= (pos_q < POS_W'(FAST_STEP)) ? '0 : pos_q - POS_W'(FAST_STEP);
                default:         pos_q <= pos_q;
            endcase
        end
    end

    assign {bus.stop_tape, bus.pause_tape, bus.forward_tape,
            bus.rewind_tape, bus.play_tape, bus.record_tape} = cmd_q;
    assign bus.fault    = fault_q;
    assign bus.state    = state_q;
    assign bus.tape_pos = pos_q;

endmodule

// File: doc/tape_transport_ctrl.md
TAPE_TRANSPORT_CTRL -- requirements
Module: tape_transport_ctrl

Interface
REQ-001 Parameter POS_W, default 16: width of tape position counter.
REQ-002 Parameter FAST_STEP, default 4: position delta per cycle in forward/rewind.
REQ-003 Parameter SETTLE_MAX, default 255: max cycles a WILL_* state waits for is_stopped.
REQ-004 Parameter PAUSE_TIMEOUT, default 1000: cycles in PAUSE before auto-stop (see Configuration).
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 stop_button, pause_button, forward_button, rewind_button, play_button, record_button  input  1 each  level buttons, synchronous to clk.
REQ-008 is_stopped  input  1  mechanism reports motor at rest.
REQ-009 stop_tape, pause_tape, forward_tape, rewind_tape, play_tape, record_tape  output  1 each  motor/head commands.
REQ-010 fault  output  1  settle timeout occurred; held until cleared.
REQ-011 state  output  4  current state encoding.
REQ-012 tape_pos  output  POS_W  current tape position.

Function
REQ-013 Buttons SHALL act on rising edge only (registered previous level; one event per press).
REQ-014 States: STOP, WILL_FWD, FWD, WILL_REW, REW, WILL_PLAY, PLAY, WILL_REC, REC, PAUSE, FAULT.
REQ-015 Outputs SHALL be Moore decode of the state register: stop_tape in STOP, FAULT and all WILL_*; pause_tape in PAUSE; others in their running state; exactly one asserted.
REQ-016 Edge priority from any non-FAULT state: stop > record+play (same cycle) > play > forward > rewind; targets STOP, WILL_REC, WILL_PLAY, WILL_FWD, WILL_REW.
REQ-017 With no higher event: WILL_x -> x when is_stopped=1; pause edge toggles PLAY<->PAUSE; pause edge ignored in other states.
REQ-018 Settle counter SHALL clear on WILL_* entry and increment each cycle in WILL_*; reaching SETTLE_MAX with is_stopped=0 -> FAULT, fault=1.
REQ-019 FAULT SHALL ignore all edges except stop, which moves to STOP and clears fault.
REQ-020 tape_pos: +1 per cycle in PLAY/REC, +FAST_STEP in FWD, -FAST_STEP in REW; saturates at 2^POS_W-1 and 0.
REQ-021 Boundary: FWD/PLAY/REC at max, or REW at 0, SHALL go to STOP next cycle; priority below stop edge, above all other edges.
REQ-022 Re-pressing the current running mode's button SHALL re-enter its WILL_* state (no special case).

Reset
REQ-023 Reset SHALL asynchronously force STOP, tape_pos=0, fault=0, counters=0, edge registers=0; stop_tape=1, other commands 0.
REQ-024 Reset mid-transition or mid-FAULT SHALL behave identically to REQ-023; first edge detection valid on the second cycle after release.

Configuration
REQ-025 Macro TAPE_PAUSE_TIMEOUT_EN defined: PAUSE counts cycles; at PAUSE_TIMEOUT -> STOP, counter cleared on PAUSE entry.
REQ-026 Macro undefined: PAUSE held indefinitely; pause counter and parameter logic absent.

Structure
REQ-027 Package tape_pkg SHALL hold state encoding constants and the state-to-command decode width.
REQ-028 Sub-module button_edge (parametrised width, rising-edge detector) SHALL serve all six buttons.

Verification
REQ-029 Reset, play edge, is_stopped=1 two cycles later -> WILL_PLAY then PLAY, play_tape=1, tape_pos increments by 1/cycle.
REQ-030 In PLAY, record+play edges together -> WILL_REC; is_stopped=1 -> REC, record_tape=1.
REQ-031 WILL_FWD with is_stopped held 0 for SETTLE_MAX cycles -> FAULT, fault=1; play edge ignored; stop edge -> STOP, fault=0.
REQ-032 POS_W=8, FAST_STEP=4, REW from tape_pos=6 -> 2, then 0 (saturated), then STOP next cycle.
REQ-033 TAPE_PAUSE_TIMEOUT_EN, PAUSE_TIMEOUT=10: PLAY, pause edge -> PAUSE; no input for 10 cycles -> STOP.
REQ-034 Assert reset while in FWD mid-count -> immediate STOP, tape_pos=0, stop_tape=1.
